// File: rtl/global_types.sv
// Shared stream types and Ethernet constants used by the packet-processing blocks.
package global_types;

  localparam int W   = 32;
  localparam int B   = 8;
  localparam int BpW = W / B;

  localparam logic [15:0] IPV4_ETHERTYPE  = 16'h0800;
  localparam logic [15:0] VLAN_ETHERTYPE  = 16'h8100;
  localparam logic [15:0] QINQ_ETHERTYPE  = 16'h88A8;
  localparam logic [15:0] VLAN2_ETHERTYPE = 16'h9100;

  typedef struct packed {
    logic         valid;
    logic         sop;
    logic         eop;
    logic [1:0]   empty;
    logic         error;
    logic [W-1:0] data;
  } avln_st;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ETH  = 2'd1,
    ST_IP   = 2'd2,
    ST_PASS = 2'd3
  } embed_state_e;

  function automatic logic is_vlan_type(input logic [15:0] etype);
    return (etype == VLAN_ETHERTYPE) || (etype == QINQ_ETHERTYPE) ||
           (etype == VLAN2_ETHERTYPE);
  endfunction

endpackage

// File: rtl/ip_id_embed_if.sv
// Avalon-ST packet stream bundle; the producer uses master, the consumer slave.
interface ip_id_embed_if;
  import global_types::*;

  avln_st pkt;

  modport master (output pkt);
  modport slave  (input  pkt);

endinterface

// File: rtl/ip_id_embed_ones_comp_add16.sv
// 16-bit ones-complement adder with end-around carry, as used by the IP checksum.
module ones_comp_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [16:0] raw_s;

  assign raw_s = {1'b0, a} + {1'b0, b};
  // A carry folded back in can never carry again: max raw is 0x1FFFE.
  assign sum   = raw_s[15:0] + {15'd0, raw_s[16]};

endmodule

// File: rtl/ip_id_embed.sv
// Egress IPv4 Identification rewriter: substitutes message symbols into the IP ID
// and patches the header checksum incrementally, with one cycle of stream latency.
module ip_id_embed
  import global_types::*;
#(
  parameter int MAX_VLAN_TAGS = 2,
  parameter int CTR_W         = 32
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  ip_id_embed_if.slave     in,
  ip_id_embed_if.master    out,
  input  logic             enable,
  input  logic [15:0]      msg_data,
  input  logic             msg_valid,
  output logic             msg_ready,
  output logic [CTR_W-1:0] embed_count
);

  embed_state_e     state_r;
  logic [7:0]       word_cnt_r;
  logic [7:0]       eth_idx_r;
  logic [7:0]       tag_cnt_r;
  logic [1:0]       ip_idx_r;
  logic             pending_r;
  logic [15:0]      old_id_r;
  logic [15:0]      new_id_r;
  avln_st           out_r;
  logic [CTR_W-1:0] embed_count_r;

  avln_st      in_s;
  avln_st      word_s;
  logic        id_hit_s;
  logic        csum_hit_s;
  logic [15:0] csum_part_s;
  logic [15:0] csum_sum_s;
  logic [15:0] csum_new_s;

  assign in_s = in.pkt;

  // ~csum_old + ~old_id + new_id, then complemented back into the header.
  ones_comp_add16 u_add_old (
    .a   (~in_s.data[15:0]),
    .b   (~old_id_r),
    .sum (csum_part_s)
  );

  ones_comp_add16 u_add_new (
    .a   (csum_part_s),
    .b   (new_id_r),
    .sum (csum_sum_s)
  );

  assign csum_new_s = ~csum_sum_s;

  // Decide whether the current input word is the ID or checksum word to patch.
  always_comb begin
    id_hit_s   = in_s.valid && !in_s.sop && (state_r == ST_IP) &&
                 (ip_idx_r == 2'd1) && enable && msg_valid;
    csum_hit_s = in_s.valid && !in_s.sop && (state_r == ST_IP) &&
                 (ip_idx_r == 2'd2) && pending_r;
    word_s     = in_s;
    if (id_hit_s) begin
      word_s.data[31:16] = msg_data;
    end else if (csum_hit_s) begin
      word_s.data[15:0] = csum_new_s;
    end else begin
      word_s = in_s;
    end
  end

  assign msg_ready   = id_hit_s;
  assign out.pkt     = out_r;
  assign embed_count = embed_count_r;

  // Header-walk FSM, output stage and statistics counter.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      word_cnt_r    <= 8'd0;
      eth_idx_r     <= 8'd3;
      tag_cnt_r     <= 8'd0;
      ip_idx_r      <= 2'd0;
      pending_r     <= 1'b0;
      old_id_r      <= 16'd0;
      new_id_r      <= 16'd0;
      out_r         <= '0;
      embed_count_r <= {CTR_W{1'b0}};
    end else begin
      out_r <= word_s;
      if (csum_hit_s) begin
        embed_count_r <= embed_count_r + CTR_W'(1);
      end
      if (in_s.valid) begin
        if (in_s.sop) begin
          // A sop always restarts the walk, whatever was in progress.
          word_cnt_r <= 8'd1;
          eth_idx_r  <= 8'd3;
          tag_cnt_r  <= 8'd0;
          ip_idx_r   <= 2'd0;
          pending_r  <= 1'b0;
          state_r    <= in_s.eop ? ST_IDLE : ST_ETH;
        end else begin
          case (state_r)
            ST_IDLE: begin
              state_r <= ST_IDLE;
            end
            ST_ETH: begin
              if (in_s.eop) begin
                state_r <= ST_IDLE;
              end else if (word_cnt_r == eth_idx_r) begin
                if (in_s.data[15:0] == IPV4_ETHERTYPE) begin
                  state_r  <= ST_IP;
                  ip_idx_r <= 2'd0;
                end else if (is_vlan_type(in_s.data[15:0]) &&
                             (tag_cnt_r < 8'(MAX_VLAN_TAGS))) begin
                  tag_cnt_r  <= tag_cnt_r + 8'd1;
                  eth_idx_r  <= eth_idx_r + 8'd1;
                  word_cnt_r <= word_cnt_r + 8'd1;
                end else begin
                  state_r <= ST_PASS;
                end
              end else begin
                word_cnt_r <= word_cnt_r + 8'd1;
              end
            end
            ST_IP: begin
              if (in_s.eop) begin
                state_r   <= ST_IDLE;
                pending_r <= 1'b0;
              end else if (ip_idx_r == 2'd1) begin
                pending_r <= id_hit_s;
                ip_idx_r  <= 2'd2;
                if (id_hit_s) begin
                  old_id_r <= in_s.data[31:16];
                  new_id_r <= msg_data;
                end else begin
                  old_id_r <= old_id_r;
                end
              end else if (ip_idx_r == 2'd2) begin
                state_r   <= ST_PASS;
                pending_r <= 1'b0;
              end else begin
                ip_idx_r <= ip_idx_r + 2'd1;
              end
            end
            ST_PASS: begin
              if (in_s.eop) begin
                state_r <= ST_IDLE;
              end else begin
                state_r <= ST_PASS;
              end
            end
            default: begin
              state_r <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ip_id_embed.sv
// Directed bench for ip_id_embed: hand-computed frames, IDs and checksums.
module tb_ip_id_embed;
  import global_types::*;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] msg_data;
  logic        msg_valid;
  logic        msg_ready;
  logic [31:0] embed_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  ip_id_embed_if in_if ();
  ip_id_embed_if out_if ();

  ip_id_embed #(.MAX_VLAN_TAGS(2), .CTR_W(32)) dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .in          (in_if.slave),
    .out         (out_if.master),
    .enable      (enable),
    .msg_data    (msg_data),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .embed_count (embed_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d);
    in_if.pkt.valid = v;
    in_if.pkt.sop   = s;
    in_if.pkt.eop   = e;
    in_if.pkt.empty = e ? 2'd2 : 2'd0;
    in_if.pkt.error = 1'b0;
    in_if.pkt.data  = d;
  endtask

  // One input word; checks msg_ready in-cycle and the registered output one cycle later.
  task automatic step(input logic v, input logic s, input logic e, input logic [31:0] d,
                      input logic [31:0] ed, input logic er, input string tag);
    logic [63:0] exp_v;
    @(negedge sys_clk);
    drive(v, s, e, d);
    #1;
    chk({tag, " rdy"}, {63'd0, msg_ready}, {63'd0, er});
    exp_v = {26'd0, v, s, e, (e ? 2'd2 : 2'd0), 1'b0, ed};
    @(posedge sys_clk);
    #1;
    chk({tag, " out"}, {26'd0, out_if.pkt.valid, out_if.pkt.sop, out_if.pkt.eop,
                         out_if.pkt.empty, out_if.pkt.error, out_if.pkt.data}, exp_v);
  endtask

  task automatic send_ipv4(input int ntags, input logic [15:0] t0, input logic [15:0] t1,
                           input logic [15:0] t2, input logic rewrite,
                           input logic [15:0] exp_csum, input logic trunc,
                           input logic gaps, input string name);
    logic [31:0] wd[$];
    logic [15:0] tt[3];
    logic [15:0] nxt;
    logic [31:0] ed;
    logic        er;
    int          ip_base;
    int          n;
    tt = '{t0, t1, t2};
    wd.push_back(32'h0000_0011);
    wd.push_back(32'h2233_4455);
    wd.push_back(32'h6677_8899);
    if (ntags == 0) begin
      wd.push_back({16'haabb, 16'h0800});
    end else begin
      wd.push_back({16'haabb, tt[0]});
      for (int i = 0; i < ntags; i++) begin
        nxt = (i + 1 < ntags) ? tt[i+1] : 16'h0800;
        wd.push_back({16'h0064 + 16'(i), nxt});
      end
    end
    ip_base = wd.size();
    wd.push_back(32'h4500_0073);
    wd.push_back(32'h0000_4000);
    wd.push_back(32'h4011_b861);
    wd.push_back(32'hc0a8_0001);
    wd.push_back(32'hc0a8_00c7);
    n = trunc ? ip_base + 2 : wd.size();
    for (int i = 0; i < n; i++) begin
      ed = wd[i];
      er = 1'b0;
      if (rewrite && i == ip_base + 1) begin
        ed[31:16] = msg_data;
        er = 1'b1;
      end
      if (rewrite && !trunc && i == ip_base + 2) ed[15:0] = exp_csum;
      step(1'b1, i == 0, i == n - 1, wd[i], ed, er, $sformatf("%s w%0d", name, i));
      if (gaps && i != n - 1) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, $sformatf("%s gap%0d", name, i));
    end
    chk({name, " count"}, {32'd0, embed_count}, {32'd0, 32'(exp_cnt)});
  endtask

  task automatic send_arp(input string name);
    logic [31:0] wd[7];
    wd = '{32'h0000_0011, 32'h2233_4455, 32'h6677_8899, 32'haabb_0806,
           32'h0001_0800, 32'h0604_0001, 32'h1111_2222};
    for (int i = 0; i < 7; i++)
      step(1'b1, i == 0, i == 6, wd[i], wd[i], 1'b0, $sformatf("%s w%0d", name, i));
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    msg_valid = 1'b1;
    msg_data  = 16'h1234;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset out", {26'd0, out_if.pkt}, 64'd0);
    chk("reset rdy", {63'd0, msg_ready}, 64'd0);
    chk("reset count", {32'd0, embed_count}, 64'd0);
    @(negedge sys_clk);
    reset_n = 1'b1;

    // Untagged: 0xb861 with ID 0x0000 -> 0x1234 gives 0xa62d.
    exp_cnt = 1;
    send_ipv4(0, 16'h0, 16'h0, 16'h0, 1'b1, 16'ha62d, 1'b0, 1'b0, "plain");
    msg_valid = 1'b0;
    send_ipv4(0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, "novalid");
    msg_valid = 1'b1;

    msg_data = 16'habcd;
    exp_cnt = 2;
    send_ipv4(1, 16'h8100, 16'h0, 16'h0, 1'b1, 16'h0c94, 1'b0, 1'b0, "vlan1");
    // 0xffff is ones-complement zero: checksum comes back unchanged.
    msg_data = 16'hffff;
    exp_cnt = 3;
    send_ipv4(2, 16'h88a8, 16'h8100, 16'h0, 1'b1, 16'hb861, 1'b0, 1'b0, "vlan2");
    send_ipv4(3, 16'h9100, 16'h8100, 16'h88a8, 1'b0, 16'h0, 1'b0, 1'b0, "vlan3");

    send_arp("arp");
    msg_data = 16'hc000;
    exp_cnt = 4;
    send_ipv4(0, 16'h0, 16'h0, 16'h0, 1'b1, 16'hf860, 1'b0, 1'b1, "gaps");

    enable = 1'b0;
    send_ipv4(0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, "disabled");
    enable = 1'b1;

    msg_data = 16'h1234;
    send_ipv4(0, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0, 1'b1, 1'b0, "trunc");
    exp_cnt = 5;
    send_ipv4(0, 16'h0, 16'h0, 16'h0, 1'b1, 16'ha62d, 1'b0, 1'b0, "after_trunc");

    // Reset while the ID word sits on the input.
    step(1'b1, 1'b1, 1'b0, 32'h0000_0011, 32'h0000_0011, 1'b0, "rst w0");
    step(1'b1, 1'b0, 1'b0, 32'h2233_4455, 32'h2233_4455, 1'b0, "rst w1");
    step(1'b1, 1'b0, 1'b0, 32'h6677_8899, 32'h6677_8899, 1'b0, "rst w2");
    step(1'b1, 1'b0, 1'b0, 32'haabb_0800, 32'haabb_0800, 1'b0, "rst w3");
    step(1'b1, 1'b0, 1'b0, 32'h4500_0073, 32'h4500_0073, 1'b0, "rst w4");
    @(negedge sys_clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_4000);
    #1;
    chk("rst id rdy", {63'd0, msg_ready}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst valid", {63'd0, out_if.pkt.valid}, 64'd0);
    chk("rst count", {32'd0, embed_count}, 64'd0);
    chk("rst rdy", {63'd0, msg_ready}, 64'd0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    reset_n = 1'b1;
    exp_cnt = 0;
    step(1'b1, 1'b0, 1'b0, 32'h4011_b861, 32'h4011_b861, 1'b0, "rst w6");
    step(1'b1, 1'b0, 1'b0, 32'hc0a8_0001, 32'hc0a8_0001, 1'b0, "rst w7");
    step(1'b1, 1'b0, 1'b1, 32'hc0a8_00c7, 32'hc0a8_00c7, 1'b0, "rst w8");
    exp_cnt = 1;
    send_ipv4(0, 16'h0, 16'h0, 16'h0, 1'b1, 16'ha62d, 1'b0, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
